hf_miller_tx: RTL and testbench



---
 rtl/hf_miller_tx_if.sv | 11 +
 rtl/hf_miller_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_hf_miller_tx.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hf_miller_tx_if.sv
// Byte-side handshake between the frame source and the modified-Miller encoder.
interface hf_miller_tx_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       tx_short;

  modport master (output tx_byte, tx_valid, tx_last, tx_short, input tx_ready);
  modport slave  (input tx_byte, tx_valid, tx_last, tx_short, output tx_ready);
endinterface

// File: rtl/hf_miller_tx.sv
// ISO14443-A reader downlink modified-Miller encoder (106 kbit/s) with odd parity,
// SOF/EOF framing and a registered carrier-pause output.
module hf_miller_tx #(
  parameter int unsigned BIT_PERIOD = 128,
  parameter int unsigned PAUSE_LEN  = 32
) (
  input  logic          ck_1356meg,
  input  logic          rst,
  hf_miller_tx_if.slave tx,
  output logic          mod_pause,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);
  localparam int unsigned PW   = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned HALF = BIT_PERIOD / 2;
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_PARITY, S_EOF0, S_EOFY} state_t;
  typedef enum logic [1:0] {SEQ_Y, SEQ_Z, SEQ_X} seq_t;

  state_t        r_state, w_state_nxt;
  seq_t          r_seq, w_seq_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic          r_cur_bit, w_cur_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic          r_par, w_par_nxt;
  logic          r_cur_last, w_cur_last_nxt;
  logic          r_cur_short, w_cur_short_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic          r_hold_vld, w_hold_vld_nxt;
  logic          r_hold_last, w_hold_last_nxt;
  logic          r_hold_short, w_hold_short_nxt;
  logic          r_last_acc, w_last_acc_nxt;
  logic          r_tx_ready;
  logic          r_mod_pause, r_busy, r_frame_done, r_underrun;

  logic          w_tx_ready, w_accept, w_in_short, w_in_last, w_bit_end;
  logic          w_load, w_done, w_underrun, w_pause_nxt;
  logic [7:0]    w_src_byte;
  logic          w_src_last, w_src_short;
  logic [2:0]    w_last_idx;

  // Reset masks ready so nothing is taken while rst is high.
  assign w_tx_ready  = r_tx_ready & ~rst;
  assign tx.tx_ready = w_tx_ready;
  assign w_accept    = tx.tx_valid & w_tx_ready;
  assign w_in_short  = tx.tx_short & (r_state == S_IDLE);
  assign w_in_last   = tx.tx_last | w_in_short;
  assign w_bit_end   = (r_phase == PH_LAST);
  assign w_last_idx  = r_cur_short ? 3'd6 : 3'd7;

  // A byte arriving on the load cycle bypasses the holding register.
  assign w_src_byte  = r_hold_vld ? r_hold       : tx.tx_byte;
  assign w_src_last  = r_hold_vld ? r_hold_last  : w_in_last;
  assign w_src_short = r_hold_vld ? r_hold_short : w_in_short;

  assign mod_pause  = r_mod_pause;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

  function automatic seq_t enc(input logic bit_v, input logic prev);
    if (bit_v)     return SEQ_X;
    else if (prev) return SEQ_Y;
    else           return SEQ_Z;
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_seq_nxt        = r_seq;
    w_phase_nxt      = r_phase;
    w_cur_bit_nxt    = r_cur_bit;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_par_nxt        = r_par;
    w_cur_last_nxt   = r_cur_last;
    w_cur_short_nxt  = r_cur_short;
    w_hold_nxt       = r_hold;
    w_hold_vld_nxt   = r_hold_vld;
    w_hold_last_nxt  = r_hold_last;
    w_hold_short_nxt = r_hold_short;
    w_last_acc_nxt   = r_last_acc;
    w_load           = 1'b0;
    w_done           = 1'b0;
    w_underrun       = 1'b0;

    if (w_accept) begin
      w_hold_nxt       = tx.tx_byte;
      w_hold_vld_nxt   = 1'b1;
      w_hold_last_nxt  = w_in_last;
      w_hold_short_nxt = w_in_short;
      if (w_in_last) w_last_acc_nxt = 1'b1;
    end

    if (r_state != S_IDLE) w_phase_nxt = w_bit_end ? '0 : r_phase + PW'(1);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = S_SOF;
          w_phase_nxt   = '0;
          w_seq_nxt     = SEQ_Z;
          w_cur_bit_nxt = 1'b0;
        end
      end
      S_SOF: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_load      = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == w_last_idx) begin
            if (r_cur_short) begin
              w_state_nxt   = S_EOF0;
              w_seq_nxt     = enc(1'b0, r_cur_bit);
              w_cur_bit_nxt = 1'b0;
            end else begin
              w_state_nxt   = S_PARITY;
              w_seq_nxt     = enc(r_par, r_cur_bit);
              w_cur_bit_nxt = r_par;
            end
          end else begin
            w_bit_cnt_nxt = 3'(r_bit_cnt + 3'd1);
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_seq_nxt     = enc(r_shift[1], r_cur_bit);
            w_cur_bit_nxt = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          if (!r_cur_last && (r_hold_vld || w_accept)) begin
            w_state_nxt = S_DATA;
            w_load      = 1'b1;
          end else begin
            w_state_nxt   = S_EOF0;
            w_seq_nxt     = enc(1'b0, r_cur_bit);
            w_cur_bit_nxt = 1'b0;
            w_underrun    = ~r_cur_last;
          end
        end
      end
      S_EOF0: begin
        if (w_bit_end) begin
          w_state_nxt   = S_EOFY;
          w_seq_nxt     = SEQ_Y;
          w_cur_bit_nxt = 1'b0;
        end
      end
      S_EOFY: begin
        if (w_bit_end) begin
          w_state_nxt    = S_IDLE;
          w_phase_nxt    = '0;
          w_seq_nxt      = SEQ_Y;
          w_done         = 1'b1;
          w_hold_vld_nxt = 1'b0;
          w_last_acc_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase

    if (w_load) begin
      w_shift_nxt     = w_src_byte;
      w_par_nxt       = ~^w_src_byte;
      w_cur_last_nxt  = w_src_last;
      w_cur_short_nxt = w_src_short;
      w_bit_cnt_nxt   = '0;
      w_seq_nxt       = enc(w_src_byte[0], r_cur_bit);
      w_cur_bit_nxt   = w_src_byte[0];
      w_hold_vld_nxt  = 1'b0;
    end
  end

  // Pause is computed for the upcoming cycle so the registered output lines up with phase.
  always_comb begin
    w_pause_nxt = 1'b0;
    case (w_seq_nxt)
      SEQ_Z:   w_pause_nxt = (32'(w_phase_nxt) < PAUSE_LEN);
      SEQ_X:   w_pause_nxt = (32'(w_phase_nxt) >= HALF) && (32'(w_phase_nxt) < HALF + PAUSE_LEN);
      default: w_pause_nxt = 1'b0;
    endcase
    if (w_state_nxt == S_IDLE) w_pause_nxt = 1'b0;
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_seq        <= SEQ_Y;
      r_phase      <= '0;
      r_cur_bit    <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_cur_last   <= 1'b0;
      r_cur_short  <= 1'b0;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_last  <= 1'b0;
      r_hold_short <= 1'b0;
      r_last_acc   <= 1'b0;
      r_tx_ready   <= 1'b1;
      r_mod_pause  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_seq        <= w_seq_nxt;
      r_phase      <= w_phase_nxt;
      r_cur_bit    <= w_cur_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_par        <= w_par_nxt;
      r_cur_last   <= w_cur_last_nxt;
      r_cur_short  <= w_cur_short_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_vld   <= w_hold_vld_nxt;
      r_hold_last  <= w_hold_last_nxt;
      r_hold_short <= w_hold_short_nxt;
      r_last_acc   <= w_last_acc_nxt;
      r_tx_ready   <= ~w_hold_vld_nxt & ~w_last_acc_nxt & ~w_load;
      r_mod_pause  <= w_pause_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_done;
      r_underrun   <= w_underrun;
    end
  end
endmodule

// File: tb/tb_hf_miller_tx.sv
// Directed bench for hf_miller_tx: three instances (PAUSE_LEN 32/1/64) share one stimulus;
// expected pause waveforms are built from hand-derived Z/X/Y sequence strings.
module tb_hf_miller_tx;
  localparam int BP   = 128;
  localparam int MAXC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tb_byte;
  logic       tb_valid, tb_last, tb_short;
  logic [2:0] mp, bz, fd, ur;

  hf_miller_tx_if u_if0 ();
  hf_miller_tx_if u_if1 ();
  hf_miller_tx_if u_if2 ();

  assign u_if0.tx_byte = tb_byte;  assign u_if0.tx_valid = tb_valid;
  assign u_if0.tx_last = tb_last;  assign u_if0.tx_short = tb_short;
  assign u_if1.tx_byte = tb_byte;  assign u_if1.tx_valid = tb_valid;
  assign u_if1.tx_last = tb_last;  assign u_if1.tx_short = tb_short;
  assign u_if2.tx_byte = tb_byte;  assign u_if2.tx_valid = tb_valid;
  assign u_if2.tx_last = tb_last;  assign u_if2.tx_short = tb_short;

  hf_miller_tx #(.BIT_PERIOD(128), .PAUSE_LEN(32)) u_dut0 (
    .ck_1356meg(clk), .rst(rst), .tx(u_if0),
    .mod_pause(mp[0]), .busy(bz[0]), .frame_done(fd[0]), .underrun(ur[0]));
  hf_miller_tx #(.BIT_PERIOD(128), .PAUSE_LEN(1)) u_dut1 (
    .ck_1356meg(clk), .rst(rst), .tx(u_if1),
    .mod_pause(mp[1]), .busy(bz[1]), .frame_done(fd[1]), .underrun(ur[1]));
  hf_miller_tx #(.BIT_PERIOD(128), .PAUSE_LEN(64)) u_dut2 (
    .ck_1356meg(clk), .rst(rst), .tx(u_if2),
    .mod_pause(mp[2]), .busy(bz[2]), .frame_done(fd[2]), .underrun(ur[2]));

  int n_pass = 0;
  int n_chk  = 0;

  // Recorder: index 0 is the cycle after the accepting edge.
  logic       cap_on;
  int         cap_n;
  logic [2:0] cap_p   [MAXC];
  logic       cap_fd  [MAXC];
  logic       cap_ur  [MAXC];
  logic       cap_bz  [MAXC];
  logic       cap_rdy [MAXC];

  always @(posedge clk) begin
    #1;
    if (!cap_on) cap_n = 0;
    else if (cap_n < MAXC) begin
      cap_p[cap_n]   = mp;
      cap_fd[cap_n]  = fd[0];
      cap_ur[cap_n]  = ur[0];
      cap_bz[cap_n]  = bz[0];
      cap_rdy[cap_n] = u_if0.tx_ready;
      cap_n = cap_n + 1;
    end
  end

  function automatic logic exp_pause(input string seq, input int pl, input int idx);
    int  k;
    int  ph;
    byte c;
    k  = idx / BP;
    ph = idx % BP;
    if (k >= seq.len()) return 1'b0;
    c = seq[k];
    if (c == "Z") return (ph < pl);
    if (c == "X") return (ph >= BP/2) && (ph < BP/2 + pl);
    return 1'b0;
  endfunction

  task automatic start_frame(input logic [7:0] b, input logic last, input logic shrt);
    int n;
    n = 0;
    @(negedge clk);
    tb_byte = b; tb_last = last; tb_short = shrt; tb_valid = 1'b1;
    while (!u_if0.tx_ready && n < 4000) begin @(negedge clk); n++; end
    n_chk++;
    if (u_if0.tx_ready === 1'b1) begin n_pass++; cap_on = 1'b1; end
    else $display("FAIL handshake: tx_ready stayed %b for %0d cycles, required 1", u_if0.tx_ready, n);
  endtask

  task automatic wait_cap(input int len);
    int n;
    n = 0;
    while (cap_n < len && n < MAXC + 10) begin @(negedge clk); n++; end
    n_chk++;
    if (cap_n >= len) n_pass++;
    else $display("FAIL capture_timeout: got %0d samples, required %0d", cap_n, len);
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_valid = 1'b0; tb_byte = '0; tb_last = 1'b0; tb_short = 1'b0; cap_on = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({u_if0.tx_ready, mp[0], bz[0], fd[0], ur[0]} !== 5'b0) begin
      $display("FAIL reset_outputs: rdy,pause,busy,done,urun got %b required 00000",
               {u_if0.tx_ready, mp[0], bz[0], fd[0], ur[0]});
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({u_if0.tx_ready, bz[0], mp[0]} !== 3'b100)
      $display("FAIL reset_release: rdy,busy,pause got %b required 100", {u_if0.tx_ready, bz[0], mp[0]});
    else n_pass++;
  endtask

  task automatic test_short_frame();
    string          seq;
    logic [BP-1:0]  got, want;
    int             len;
    seq = "ZZXXYZXYZY";
    len = seq.len() * BP;
    start_frame(8'h26, 1'b0, 1'b1);
    @(negedge clk); tb_valid = 1'b0;
    wait_cap(len + 2);
    cap_on = 1'b0;
    for (int k = 0; k < seq.len(); k++) begin
      for (int p = 0; p < BP; p++) begin
        got[p]  = cap_p[k*BP + p][0];
        want[p] = exp_pause(seq, 32, k*BP + p);
      end
      n_chk++;
      if (got !== want) $display("FAIL short_bit%0d pause got %h required %h", k, got, want);
      else n_pass++;
    end
    n_chk++;
    if ({cap_fd[len-1], cap_fd[len], cap_bz[len-1], cap_bz[len]} !== 4'b0110)
      $display("FAIL short_end: done[1279],done[1280],busy[1279],busy[1280] got %b required 0110",
               {cap_fd[len-1], cap_fd[len], cap_bz[len-1], cap_bz[len]});
    else n_pass++;
  endtask

  task automatic test_single_byte();
    string          seq;
    logic [BP-1:0]  got, want;
    int             len;
    seq = "ZXXYZXYZXXYY";
    len = seq.len() * BP;
    start_frame(8'h93, 1'b1, 1'b0);
    @(negedge clk); tb_valid = 1'b0;
    wait_cap(len + 2);
    cap_on = 1'b0;
    n_chk++;
    if (cap_p[0][0] !== 1'b1 || cap_bz[0] !== 1'b1)
      $display("FAIL single_latency: pause,busy at t+1 got %b%b required 11", cap_p[0][0], cap_bz[0]);
    else n_pass++;
    for (int k = 0; k < seq.len(); k++) begin
      for (int p = 0; p < BP; p++) begin
        got[p]  = cap_p[k*BP + p][0];
        want[p] = exp_pause(seq, 32, k*BP + p);
      end
      n_chk++;
      if (got !== want) $display("FAIL single_bit%0d pause got %h required %h", k, got, want);
      else n_pass++;
    end
    n_chk++;
    if ({cap_fd[len-1], cap_fd[len], cap_bz[len]} !== 3'b010)
      $display("FAIL single_end: done[1535],done[1536],busy[1536] got %b required 010",
               {cap_fd[len-1], cap_fd[len], cap_bz[len]});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    string          seq;
    logic [BP-1:0]  got, want;
    int             len, n, ur_cnt;
    seq = "ZXXYZXYZXXYZZZZXYZZZY";
    len = seq.len() * BP;
    start_frame(8'h93, 1'b0, 1'b0);
    @(negedge clk);
    tb_byte = 8'h20; tb_last = 1'b1;
    n = 0;
    while (!u_if0.tx_ready && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk); tb_valid = 1'b0; tb_last = 1'b0;
    wait_cap(len + 2);
    cap_on = 1'b0;
    n_chk++;
    if ({cap_rdy[127], cap_rdy[128], cap_rdy[129], cap_rdy[130]} !== 4'b0010)
      $display("FAIL b2b_ready: rdy[127..130] got %b required 0010",
               {cap_rdy[127], cap_rdy[128], cap_rdy[129], cap_rdy[130]});
    else n_pass++;
    for (int k = 0; k < seq.len(); k++) begin
      for (int p = 0; p < BP; p++) begin
        got[p]  = cap_p[k*BP + p][0];
        want[p] = exp_pause(seq, 32, k*BP + p);
      end
      n_chk++;
      if (got !== want) $display("FAIL b2b_bit%0d pause got %h required %h", k, got, want);
      else n_pass++;
    end
    ur_cnt = 0;
    for (int i = 0; i <= len; i++) if (cap_ur[i] === 1'b1) ur_cnt++;
    n_chk++;
    if (ur_cnt != 0) $display("FAIL b2b_underrun: pulses got %0d required 0", ur_cnt);
    else n_pass++;
    n_chk++;
    if ({cap_fd[len-1], cap_fd[len], cap_bz[len-1]} !== 3'b011)
      $display("FAIL b2b_end: done[2687],done[2688],busy[2687] got %b required 011",
               {cap_fd[len-1], cap_fd[len], cap_bz[len-1]});
    else n_pass++;
  endtask

  task automatic test_underrun();
    string          seq;
    logic [BP-1:0]  got, want;
    int             len, n, ur_cnt;
    seq = "ZZZZZXYXYXYY";
    len = seq.len() * BP;
    start_frame(8'h50, 1'b0, 1'b0);
    @(negedge clk); tb_valid = 1'b0;
    n = 0;
    while (cap_n < 1300 && n < 2000) begin @(negedge clk); n++; end
    tb_byte = 8'hAA; tb_last = 1'b1; tb_valid = 1'b1;
    n = 0;
    while (!u_if0.tx_ready && n < 300) begin @(negedge clk); n++; end
    @(negedge clk); tb_valid = 1'b0; tb_last = 1'b0;
    wait_cap(len + 6);
    cap_on = 1'b0;
    for (int k = 0; k < seq.len(); k++) begin
      for (int p = 0; p < BP; p++) begin
        got[p]  = cap_p[k*BP + p][0];
        want[p] = exp_pause(seq, 32, k*BP + p);
      end
      n_chk++;
      if (got !== want) $display("FAIL urun_bit%0d pause got %h required %h", k, got, want);
      else n_pass++;
    end
    ur_cnt = 0;
    for (int i = 0; i < len + 6; i++) if (cap_ur[i] === 1'b1) ur_cnt++;
    n_chk++;
    if (cap_ur[1280] !== 1'b1 || ur_cnt != 1)
      $display("FAIL urun_pulse: urun[1280]=%b count %0d required 1 and 1", cap_ur[1280], ur_cnt);
    else n_pass++;
    n_chk++;
    if ({cap_fd[len], cap_rdy[len], cap_bz[len+1], cap_bz[len+4]} !== 4'b1100)
      $display("FAIL urun_stale: done,rdy at end, busy +1,+4 got %b required 1100",
               {cap_fd[len], cap_rdy[len], cap_bz[len+1], cap_bz[len+4]});
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    string          seq;
    logic [BP-1:0]  got, want;
    int             len, fd_cnt;
    start_frame(8'h0F, 1'b1, 1'b0);
    @(negedge clk); tb_valid = 1'b0; tb_last = 1'b0; cap_on = 1'b0;
    repeat (454) @(negedge clk);
    n_chk++;
    if (mp[0] !== 1'b1) $display("FAIL midrst_pre: pause at bit3 ph70 got %b required 1", mp[0]);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mp[0], bz[0], u_if0.tx_ready} !== 3'b000)
      $display("FAIL midrst_after: pause,busy,rdy got %b required 000", {mp[0], bz[0], u_if0.tx_ready});
    else n_pass++;
    rst = 1'b0;
    fd_cnt = 0;
    repeat (200) begin @(negedge clk); if (fd[0] === 1'b1 || bz[0] === 1'b1) fd_cnt++; end
    n_chk++;
    if (fd_cnt != 0 || u_if0.tx_ready !== 1'b1)
      $display("FAIL midrst_quiet: done/busy cycles %0d rdy %b required 0 and 1", fd_cnt, u_if0.tx_ready);
    else n_pass++;
    seq = "ZXXYZXYZXXYY";
    len = seq.len() * BP;
    start_frame(8'h93, 1'b1, 1'b0);
    @(negedge clk); tb_valid = 1'b0; tb_last = 1'b0;
    wait_cap(len + 2);
    cap_on = 1'b0;
    for (int k = 0; k < seq.len(); k++) begin
      for (int p = 0; p < BP; p++) begin
        got[p]  = cap_p[k*BP + p][0];
        want[p] = exp_pause(seq, 32, k*BP + p);
      end
      n_chk++;
      if (got !== want) $display("FAIL midrst_fresh_bit%0d pause got %h required %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_pause_width();
    string          seq;
    logic [BP-1:0]  got, want;
    int             len, w1, w2;
    seq = "ZXXYZXYZXXYY";
    len = seq.len() * BP;
    start_frame(8'h93, 1'b1, 1'b0);
    @(negedge clk); tb_valid = 1'b0; tb_last = 1'b0;
    wait_cap(len + 2);
    cap_on = 1'b0;
    for (int d = 1; d <= 2; d++) begin
      for (int k = 0; k < seq.len(); k++) begin
        for (int p = 0; p < BP; p++) begin
          got[p]  = cap_p[k*BP + p][d];
          want[p] = exp_pause(seq, (d == 1) ? 1 : 64, k*BP + p);
        end
        n_chk++;
        if (got !== want) $display("FAIL width_dut%0d_bit%0d pause got %h required %h", d, k, got, want);
        else n_pass++;
      end
    end
    w1 = 0; w2 = 0;
    for (int p = 0; p < BP; p++) begin
      if (cap_p[BP + p][1] === 1'b1) w1++;
      if (cap_p[BP + p][2] === 1'b1) w2++;
    end
    n_chk++;
    if (w1 != 1 || w2 != 64) $display("FAIL width_x: widths got %0d/%0d required 1/64", w1, w2);
    else n_pass++;
    n_chk++;
    if ({cap_p[2*BP-1][2], cap_p[2*BP][2], cap_p[3*BP-1][2], cap_p[3*BP][2]} !== 4'b1010)
      $display("FAIL width_spill: ph127/ph0 across bits 1-2,2-3 got %b required 1010",
               {cap_p[2*BP-1][2], cap_p[2*BP][2], cap_p[3*BP-1][2], cap_p[3*BP][2]});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_pause_width();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
